alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
Parametrised, clocked successor to the combinational ALU (alu_top). It adds a valid/ready handshake, registered results, and an iterative multi-cycle unsigned multiplier and divider with HI/LO outputs. It sits between the instruction-decode stage and writeback, and consumes the same decoded instruction ID and register operands that decode produces.

Parameters:
WIDTH, 32, operand/result width in bits (>=8, power of 2)
ID_W, 32, width of decoded instruction ID input
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset; sampled on rising clk
in_valid  in  1  ID/operands valid
in_ready  out  1  unit can accept an operation
ID  in  ID_W  decoded instruction ID
rs  in  WIDTH  operand 1
rt  in  WIDTH  operand 2 (register value or extended immediate)
rd  out  WIDTH  result register
hi  out  WIDTH  mul high word / div remainder
lo  out  WIDTH  mul low word / div quotient
out_valid  out  1  one-cycle pulse: new result available
ovf  out  1  signed overflow of last add/sub
div_zero  out  1  last divide had rt==0
illegal  out  1  last ID not executed by this unit

Behaviour:
- Reset is synchronous and active-low. On the first rising clk with reset==0, all registers are cleared:
  - rd, hi, lo = 0
  - out_valid, ovf, div_zero, illegal = 0
  - FSM = IDLE, counter = 0
  - in_ready = 1 from the first cycle after reset is released.
- Reset mid-operation aborts the mul/div. No out_valid is produced for the aborted operation.
- Accept: an operation is accepted on a rising edge where in_valid && in_ready. Operands and ID are captured at that edge.
- in_ready = (state==IDLE). It is combinational from state only, with no dependence on in_valid.
- ID map:
  - 1/3 add: rd = rs+rt
  - 2/4 sub: rd = rs-rt
  - 7/8 and: rd = rs&rt
  - 9/10 or: rd = rs|rt
  - 11 xor: rd = rs^rt
  - 12 sll: rd = rs << rt[log2(WIDTH)-1:0]
  - 15 srl: logical right shift, same shift-amount bits
  - 16 sra: arithmetic right shift, same shift-amount bits
  - 24/25 slt: rd = {0..,($signed(rs)<$signed(rt))}
  - 26 sltu: unsigned compare
  - 30 mul
  - 31 div
- Any other ID (e.g. 13 lw, 14 sw, 21 j):
  - accepted in 1 cycle
  - rd, hi, lo unchanged
  - illegal = 1
  - out_valid pulses.
- Single-cycle ops: rd is registered at the accept edge, and out_valid is high for exactly the following cycle (latency 1).
  - illegal is cleared.
  - ovf is updated only by IDs 1-4 (two's-complement signed overflow); every other op clears it.
  - Back-to-back single-cycle ops sustain 1 per cycle.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE -> MUL on accepted ID 30.
  - IDLE -> DIV on accepted ID 31.
  - MUL/DIV -> DONE when counter reaches WIDTH-1.
  - DONE -> IDLE unconditionally.
- MUL: unsigned shift-add, one partial product per cycle for WIDTH cycles.
  - In DONE: {hi,lo} = rs*rt (2*WIDTH bits), rd = lo, out_valid pulses the cycle after DONE.
  - Total latency from accept to out_valid: WIDTH+2 cycles.
- DIV: unsigned restoring division, one quotient bit per cycle, same latency as MUL.
  - Result: lo = quotient, hi = remainder, rd = lo.
- DIV with rt==0: still takes full latency. lo = all-ones, hi = rs, rd = lo, div_zero = 1.
  - Every other accepted op clears div_zero.
- in_valid while busy is ignored. The producer must hold in_valid and operands until in_ready.
- out_valid has no backpressure. Results remain in rd/hi/lo until overwritten.

Optional Feature:
ALU_DIV_EN
- Defined: the DIV state and divider datapath are compiled in; ID 31 behaves as above.
- Undefined: no DIV state and no divider logic. ID 31 is treated as an unlisted ID: single cycle, rd/hi/lo unchanged, illegal=1, div_zero stays 0.

Test Plan:
- Reset low for 2 clks, then high -> rd=hi=lo=0, out_valid=0, in_ready=1 on the first cycle after release.
- ID=1 rs=10 rt=12, then next cycle ID=2 rs=10 rt=100 -> rd=22 with out_valid the cycle after accept, then rd=-90 (0xFFFFFFA6) the following cycle; ovf=0. Then ID=1 rs=0x7FFFFFFF rt=1 -> rd=0x80000000, ovf=1.
- ID=24 rs=17 rt=6 -> rd=0; then rs=-5 rt=6 -> rd=1; ID=26 rs=-5 rt=6 -> rd=0; ID=21 -> rd unchanged at 0, illegal=1.
- ID=30 rs=0xFFFFFFFF rt=2 -> in_ready=0 for 33 cycles, a new in_valid during that time is ignored; out_valid at accept+34 with hi=1, lo=rd=0xFFFFFFFE.
- ID=31 rs=100 rt=7 -> lo=rd=14, hi=2 at accept+34; ID=31 rs=5 rt=0 -> lo=0xFFFFFFFF, hi=5, div_zero=1. Without ALU_DIV_EN: ID=31 -> illegal=1 after 1 cycle, rd unchanged.
- ID=30 accepted, reset low at accept+10 -> no out_valid, all outputs 0, in_ready=1 after release; a following ID=1 rs=3 rt=4 gives rd=7.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: clocked ALU with valid/ready accept, registered results and iterative unsigned mul/div.
// Latency: 1 cycle accept-to-out_valid for single-cycle ops, WIDTH+2 cycles for mul/div.
// Backpressure: in_ready low while mul/div iterate; out_valid is a pulse and cannot be stalled.
// Optional: define ALU_DIV_EN to build the restoring divider (ID 31); otherwise ID 31 is illegal.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int ID_W  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ID_W-1:0]  ID,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  output logic [WIDTH-1:0] rd,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             out_valid,
  output logic             ovf,
  output logic             div_zero,
  output logic             illegal
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam int SH_W  = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

`ifdef ALU_DIV_EN
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_e;
`endif

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA,
    OP_SLT, OP_SLTU, OP_MUL, OP_DIV, OP_ILL
  } op_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   rd_q, hi_q, lo_q;
  logic               out_valid_q, ovf_q, div_zero_q, illegal_q;
  // Shared iteration register: {partial high / remainder, multiplier / dividend-quotient}.
  logic [2*WIDTH-1:0] p_q;
  // Multiplicand for mul, divisor for div.
  logic [WIDTH-1:0]   m_q;

  op_e                op;
  logic [WIDTH-1:0]   sum, dif, alu_res;
  logic               alu_ovf;
  logic [SH_W-1:0]    shamt;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

`ifdef ALU_DIV_EN
  logic               div_is_q;
  logic               dz_q;
  logic [WIDTH:0]     div_shift, div_trial;
  logic [2*WIDTH-1:0] div_next;
`endif

  assign in_ready  = (state_q == S_IDLE);
  assign rd        = rd_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign out_valid = out_valid_q;
  assign ovf       = ovf_q;
  assign div_zero  = div_zero_q;
  assign illegal   = illegal_q;

  // Map the decoded instruction ID onto the operation this unit performs.
  always_comb begin
    op = OP_ILL;
    case (ID)
      ID_W'(1),  ID_W'(3):  op = OP_ADD;
      ID_W'(2),  ID_W'(4):  op = OP_SUB;
      ID_W'(7),  ID_W'(8):  op = OP_AND;
      ID_W'(9),  ID_W'(10): op = OP_OR;
      ID_W'(11):            op = OP_XOR;
      ID_W'(12):            op = OP_SLL;
      ID_W'(15):            op = OP_SRL;
      ID_W'(16):            op = OP_SRA;
      ID_W'(24), ID_W'(25): op = OP_SLT;
      ID_W'(26):            op = OP_SLTU;
      ID_W'(30):            op = OP_MUL;
`ifdef ALU_DIV_EN
      ID_W'(31):            op = OP_DIV;
`endif
      default:              op = OP_ILL;
    endcase
  end

  assign shamt = rt[SH_W-1:0];
  assign sum   = rs + rt;
  assign dif   = rs - rt;

  // Single-cycle result and signed-overflow flag; ops that do not write rd keep it.
  always_comb begin
    alu_res = rd_q;
    alu_ovf = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (rs[WIDTH-1] == rt[WIDTH-1]) && (sum[WIDTH-1] != rs[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = dif;
        alu_ovf = (rs[WIDTH-1] != rt[WIDTH-1]) && (dif[WIDTH-1] != rs[WIDTH-1]);
      end
      OP_AND:  alu_res = rs & rt;
      OP_OR:   alu_res = rs | rt;
      OP_XOR:  alu_res = rs ^ rt;
      OP_SLL:  alu_res = rs << shamt;
      OP_SRL:  alu_res = rs >> shamt;
      OP_SRA:  alu_res = $signed(rs) >>> shamt;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(rs) < $signed(rt))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (rs < rt)};
      default: alu_res = rd_q;
    endcase
  end

  // Shift-add step: add multiplicand into the high half when the current multiplier bit is set,
  // then shift the whole product right; the carry lands in the top bit.
  assign mul_sum  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, p_q[WIDTH-1:1]};

`ifdef ALU_DIV_EN
  // Restoring step: bring the next dividend bit into the remainder, keep the difference if it
  // did not go negative. The remainder stays below the divisor, so WIDTH+1 bits suffice.
  assign div_shift = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, m_q};
  assign div_next  = div_trial[WIDTH] ? {div_shift[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0}
                                      : {div_trial[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
`endif

  // Control FSM with registered results: accept, iterate mul/div, publish in DONE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rd_q        <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      div_zero_q  <= 1'b0;
      illegal_q   <= 1'b0;
      p_q         <= '0;
      m_q         <= '0;
`ifdef ALU_DIV_EN
      div_is_q    <= 1'b0;
      dz_q        <= 1'b0;
`endif
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            illegal_q  <= (op == OP_ILL);
            ovf_q      <= alu_ovf;
            div_zero_q <= 1'b0;
            cnt_q      <= '0;
            case (op)
              OP_MUL: begin
                state_q  <= S_MUL;
                p_q      <= {{WIDTH{1'b0}}, rt};
                m_q      <= rs;
`ifdef ALU_DIV_EN
                div_is_q <= 1'b0;
                dz_q     <= 1'b0;
`endif
              end
`ifdef ALU_DIV_EN
              OP_DIV: begin
                state_q  <= S_DIV;
                p_q      <= {{WIDTH{1'b0}}, rs};
                m_q      <= rt;
                div_is_q <= 1'b1;
                dz_q     <= (rt == '0);
              end
`endif
              OP_ILL: out_valid_q <= 1'b1;
              default: begin
                rd_q        <= alu_res;
                out_valid_q <= 1'b1;
              end
            endcase
          end
        end
        S_MUL: begin
          p_q   <= mul_next;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) state_q <= S_DONE;
        end
`ifdef ALU_DIV_EN
        S_DIV: begin
          p_q   <= div_next;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) state_q <= S_DONE;
        end
`endif
        S_DONE: begin
          hi_q        <= p_q[2*WIDTH-1:WIDTH];
          lo_q        <= p_q[WIDTH-1:0];
          rd_q        <= p_q[WIDTH-1:0];
          out_valid_q <= 1'b1;
          state_q     <= S_IDLE;
`ifdef ALU_DIV_EN
          // Dividing by zero naturally leaves rs in the remainder; the quotient is pinned to
          // all-ones so the result does not depend on the iteration details.
          if (div_is_q && dz_q) begin
            lo_q       <= '1;
            rd_q       <= '1;
            div_zero_q <= 1'b1;
          end
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: randomized and directed checks of alu_seq against a plain-arithmetic model.
// Inputs are driven and outputs sampled on the falling clock edge.
// Divider checks follow the ALU_DIV_EN build option.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] ID, rs, rt;
  logic [31:0] rd, hi, lo;
  logic        out_valid, ovf, div_zero, illegal;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(32), .ID_W(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .ID(ID),
    .rs(rs), .rt(rt), .rd(rd), .hi(hi), .lo(lo), .out_valid(out_valid),
    .ovf(ovf), .div_zero(div_zero), .illegal(illegal)
  );

  int total = 0;
  int bad   = 0;

  localparam longint SMAX = 2147483647;
  localparam longint SMIN = -SMAX - 1;

  // Architectural model state.
  logic [31:0] m_rd = '0, m_hi = '0, m_lo = '0;
  logic        m_ovf = 1'b0, m_dz = 1'b0, m_ill = 1'b0;

  int unsigned all_ids[22] = '{1, 2, 3, 4, 7, 8, 9, 10, 11, 12, 15, 16, 24, 25, 26,
                               30, 31, 13, 14, 21, 0, 99};
  int unsigned sc_ids[13]  = '{1, 2, 3, 4, 7, 9, 11, 12, 15, 16, 24, 26, 21};

  task automatic model_reset();
    m_rd = '0; m_hi = '0; m_lo = '0; m_ovf = 1'b0; m_dz = 1'b0; m_ill = 1'b0;
  endtask

  // Apply one instruction to the model; lat is the expected accept-to-out_valid cycle count.
  task automatic ref_exec(input logic [31:0] id, input logic [31:0] a, input logic [31:0] b,
                          output int lat);
    longint      sa, sb, r;
    logic [63:0] p;
    int          sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b % 32);
    lat = 1; m_ovf = 1'b0; m_dz = 1'b0; m_ill = 1'b0;
    case (id)
      1, 3:   begin r = sa + sb; m_rd = a + b; m_ovf = (r > SMAX) || (r < SMIN); end
      2, 4:   begin r = sa - sb; m_rd = a - b; m_ovf = (r > SMAX) || (r < SMIN); end
      7, 8:   m_rd = a & b;
      9, 10:  m_rd = a | b;
      11:     m_rd = a ^ b;
      12:     m_rd = a << sh;
      15:     m_rd = a >> sh;
      16:     m_rd = $signed(a) >>> sh;
      24, 25: m_rd = (sa < sb) ? 32'd1 : 32'd0;
      26:     m_rd = (a < b) ? 32'd1 : 32'd0;
      30: begin
        p = 64'(a) * 64'(b);
        m_hi = p[63:32]; m_lo = p[31:0]; m_rd = m_lo; lat = 34;
      end
`ifdef ALU_DIV_EN
      31: begin
        lat = 34;
        if (b == 0) begin m_lo = 32'hFFFF_FFFF; m_hi = a; m_dz = 1'b1; end
        else begin m_lo = a / b; m_hi = a % b; end
        m_rd = m_lo;
      end
`endif
      default: m_ill = 1'b1;
    endcase
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  // Present one op from a falling edge; returns cycles until out_valid (capped at 100).
  task automatic issue(input logic [31:0] id, input logic [31:0] a, input logic [31:0] b,
                       output int lat);
    int guard = 0;
    while (!in_ready && guard < 200) begin @(negedge clk); guard++; end
    in_valid = 1'b1; ID = id; rs = a; rt = b;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; ID = '0; rs = '0; rt = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    total++; if (rd !== 32'd0) begin bad++; $display("FAIL reset_rd got=%h exp=0", rd); end
    total++; if (hi !== 32'd0) begin bad++; $display("FAIL reset_hi got=%h exp=0", hi); end
    total++; if (lo !== 32'd0) begin bad++; $display("FAIL reset_lo got=%h exp=0", lo); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if ({ovf, div_zero, illegal} !== 3'b000) begin
      bad++; $display("FAIL reset_flags got=%b exp=000", {ovf, div_zero, illegal});
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [31:0] a, b, id;
    in_valid = 1'b1; ID = 32'd1; rs = 32'd10; rt = 32'd12;
    ref_exec(32'd1, 32'd10, 32'd12, lat);
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || rd !== 32'd22) begin
      bad++; $display("FAIL b2b_add got vld=%b rd=%h exp vld=1 rd=00000016", out_valid, rd);
    end
    ID = 32'd2; rs = 32'd10; rt = 32'd100;
    ref_exec(32'd2, 32'd10, 32'd100, lat);
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || rd !== 32'hFFFF_FFA6 || ovf !== 1'b0) begin
      bad++; $display("FAIL b2b_sub got vld=%b rd=%h ovf=%b exp vld=1 rd=ffffffa6 ovf=0", out_valid, rd, ovf);
    end
    for (int i = 0; i < 8; i++) begin
      id = sc_ids[$urandom_range(0, 12)]; a = rnd_opnd(); b = rnd_opnd();
      ID = id; rs = a; rt = b;
      ref_exec(id, a, b, lat);
      @(negedge clk);
      total++; if (out_valid !== 1'b1 || rd !== m_rd || ovf !== m_ovf || illegal !== m_ill) begin
        bad++; $display("FAIL b2b_rand id=%0d got vld=%b rd=%h ovf=%b ill=%b exp vld=1 rd=%h ovf=%b ill=%b",
                        id, out_valid, rd, ovf, illegal, m_rd, m_ovf, m_ill);
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_idle_vld got=%b exp=0", out_valid); end
  endtask

  task automatic test_ovf();
    int lat, elat;
    ref_exec(32'd1, 32'h7FFF_FFFF, 32'd1, elat);
    issue(32'd1, 32'h7FFF_FFFF, 32'd1, lat);
    total++; if (rd !== 32'h8000_0000 || ovf !== 1'b1 || lat !== 1) begin
      bad++; $display("FAIL ovf_add got rd=%h ovf=%b lat=%0d exp rd=80000000 ovf=1 lat=1", rd, ovf, lat);
    end
    ref_exec(32'd4, 32'h8000_0000, 32'd1, elat);
    issue(32'd4, 32'h8000_0000, 32'd1, lat);
    total++; if (rd !== 32'h7FFF_FFFF || ovf !== 1'b1) begin
      bad++; $display("FAIL ovf_sub got rd=%h ovf=%b exp rd=7fffffff ovf=1", rd, ovf);
    end
    ref_exec(32'd11, 32'hF0F0_F0F0, 32'hFFFF_0000, elat);
    issue(32'd11, 32'hF0F0_F0F0, 32'hFFFF_0000, lat);
    total++; if (rd !== 32'h0F0F_F0F0 || ovf !== 1'b0) begin
      bad++; $display("FAIL ovf_clear got rd=%h ovf=%b exp rd=0f0ff0f0 ovf=0", rd, ovf);
    end
  endtask

  task automatic test_slt_illegal();
    int lat, elat;
    ref_exec(32'd24, 32'd17, 32'd6, elat);
    issue(32'd24, 32'd17, 32'd6, lat);
    total++; if (rd !== 32'd0) begin bad++; $display("FAIL slt_pos got=%h exp=0", rd); end
    ref_exec(32'd24, -32'sd5, 32'd6, elat);
    issue(32'd24, -32'sd5, 32'd6, lat);
    total++; if (rd !== 32'd1) begin bad++; $display("FAIL slt_neg got=%h exp=1", rd); end
    ref_exec(32'd26, -32'sd5, 32'd6, elat);
    issue(32'd26, -32'sd5, 32'd6, lat);
    total++; if (rd !== 32'd0) begin bad++; $display("FAIL sltu got=%h exp=0", rd); end
    ref_exec(32'd21, 32'd99, 32'd98, elat);
    issue(32'd21, 32'd99, 32'd98, lat);
    total++; if (rd !== 32'd0 || illegal !== 1'b1 || lat !== 1) begin
      bad++; $display("FAIL illegal_j got rd=%h ill=%b lat=%0d exp rd=0 ill=1 lat=1", rd, illegal, lat);
    end
  endtask

  task automatic test_mul_busy();
    int elat, low = 0, early = 0;
    ref_exec(32'd30, 32'hFFFF_FFFF, 32'd2, elat);
    in_valid = 1'b1; ID = 32'd30; rs = 32'hFFFF_FFFF; rt = 32'd2;
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      if (k == 1) begin ID = 32'd1; rs = 32'd1; rt = 32'd1; end
      if (k == 10) in_valid = 1'b0;
      if (!in_ready) low++;
      if (out_valid) early++;
    end
    @(negedge clk);
    total++; if (low !== 33) begin bad++; $display("FAIL mul_busy_cycles got=%0d exp=33", low); end
    total++; if (early !== 0) begin bad++; $display("FAIL mul_early_vld got=%0d exp=0", early); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mul_vld_at_34 got=%b exp=1", out_valid); end
    total++; if (hi !== 32'd1 || lo !== 32'hFFFF_FFFE || rd !== 32'hFFFF_FFFE) begin
      bad++; $display("FAIL mul_result got hi=%h lo=%h rd=%h exp hi=00000001 lo=rd=fffffffe", hi, lo, rd);
    end
    total++; if (hi !== m_hi || lo !== m_lo) begin
      bad++; $display("FAIL mul_model got hi=%h lo=%h exp hi=%h lo=%h", hi, lo, m_hi, m_lo);
    end
  endtask

`ifdef ALU_DIV_EN
  task automatic test_div();
    int lat, elat;
    ref_exec(32'd31, 32'd100, 32'd7, elat);
    issue(32'd31, 32'd100, 32'd7, lat);
    total++; if (lat !== 34 || lo !== 32'd14 || rd !== 32'd14 || hi !== 32'd2) begin
      bad++; $display("FAIL div_basic got lat=%0d lo=%h rd=%h hi=%h exp lat=34 lo=rd=e hi=2", lat, lo, rd, hi);
    end
    ref_exec(32'd31, 32'd5, 32'd0, elat);
    issue(32'd31, 32'd5, 32'd0, lat);
    total++; if (lat !== 34 || lo !== 32'hFFFF_FFFF || hi !== 32'd5 || div_zero !== 1'b1) begin
      bad++; $display("FAIL div_zero got lat=%0d lo=%h hi=%h dz=%b exp lat=34 lo=ffffffff hi=5 dz=1", lat, lo, hi, div_zero);
    end
    ref_exec(32'd1, 32'd1, 32'd1, elat);
    issue(32'd1, 32'd1, 32'd1, lat);
    total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL div_zero_clear got=%b exp=0", div_zero); end
  endtask
`else
  task automatic test_div();
    int lat, elat;
    logic [31:0] prev;
    prev = rd;
    ref_exec(32'd31, 32'd100, 32'd7, elat);
    issue(32'd31, 32'd100, 32'd7, lat);
    total++; if (lat !== 1 || illegal !== 1'b1 || rd !== prev || div_zero !== 1'b0) begin
      bad++; $display("FAIL div_disabled got lat=%0d ill=%b rd=%h dz=%b exp lat=1 ill=1 rd=%h dz=0", lat, illegal, rd, div_zero, prev);
    end
  endtask
`endif

  task automatic test_reset_mid_op();
    int lat, elat, seen = 0;
    in_valid = 1'b1; ID = 32'd30; rs = 32'h1234_5678; rt = 32'h9ABC_DEF1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 2; k <= 10; k++) begin @(negedge clk); if (out_valid) seen++; end
    reset = 1'b0;
    repeat (2) begin @(negedge clk); if (out_valid) seen++; end
    reset = 1'b1;
    model_reset();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL abort_in_ready got=%b exp=1", in_ready); end
    total++; if ({rd, hi, lo} !== 96'd0 || {ovf, div_zero, illegal} !== 3'b000) begin
      bad++; $display("FAIL abort_outputs got rd=%h hi=%h lo=%h flags=%b exp all 0", rd, hi, lo, {ovf, div_zero, illegal});
    end
    for (int k = 0; k < 40; k++) begin @(negedge clk); if (out_valid) seen++; end
    total++; if (seen !== 0) begin bad++; $display("FAIL abort_no_vld got=%0d exp=0", seen); end
    ref_exec(32'd1, 32'd3, 32'd4, elat);
    issue(32'd1, 32'd3, 32'd4, lat);
    total++; if (rd !== 32'd7 || lat !== 1) begin
      bad++; $display("FAIL abort_then_add got rd=%h lat=%0d exp rd=7 lat=1", rd, lat);
    end
  endtask

  task automatic test_random();
    int lat, elat;
    logic [31:0] id, a, b;
    for (int i = 0; i < 40; i++) begin
      id = all_ids[$urandom_range(0, 21)]; a = rnd_opnd(); b = rnd_opnd();
      ref_exec(id, a, b, elat);
      issue(id, a, b, lat);
      total++; if (lat !== elat) begin bad++; $display("FAIL rand_lat id=%0d got=%0d exp=%0d", id, lat, elat); end
      total++; if (rd !== m_rd || hi !== m_hi || lo !== m_lo) begin
        bad++; $display("FAIL rand_regs id=%0d a=%h b=%h got rd=%h hi=%h lo=%h exp rd=%h hi=%h lo=%h",
                        id, a, b, rd, hi, lo, m_rd, m_hi, m_lo);
      end
      total++; if ({ovf, div_zero, illegal} !== {m_ovf, m_dz, m_ill}) begin
        bad++; $display("FAIL rand_flags id=%0d a=%h b=%h got=%b exp=%b", id, a, b,
                        {ovf, div_zero, illegal}, {m_ovf, m_dz, m_ill});
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_ovf();
    test_slt_illegal();
    test_mul_busy();
    test_div();
    test_reset_mid_op();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
